// File: rtl/regfile_pkg.sv
// Shared constants and enums for the register-file port arbiter.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and
// moves only when the caller reports that the grant was consumed.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  req_id_e last_q, last_d;

  // Reset pretends B won last so that A has priority first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_q == REQ_A) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (advance) begin
      last_d = grant[1] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Clears the register file after reset, then gives A and B private read ports
// and round-robin access to the single write port.
// Handshake: a request transfers on a posedge where valid && ready; requesters
// hold valid/write/addr/data stable until then; responses cannot be stalled.
module regfile_port_arbiter #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              ReqA_valid,
  input  logic              ReqA_write,
  input  logic [ADDR_W-1:0] ReqA_addr,
  input  logic [DATA_W-1:0] ReqA_data,
  output logic              ReqA_ready,
  output logic              RespA_valid,
  output logic [DATA_W-1:0] RespA_data,
  input  logic              ReqB_valid,
  input  logic              ReqB_write,
  input  logic [ADDR_W-1:0] ReqB_addr,
  input  logic [DATA_W-1:0] ReqB_data,
  output logic              ReqB_ready,
  output logic              RespB_valid,
  output logic [DATA_W-1:0] RespB_data,
  output logic              InitDone,
  output logic [DATA_W-1:0] WriteData,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] ReadRegister1,
  input  logic [DATA_W-1:0] ReadData1,
  output logic [ADDR_W-1:0] ReadRegister2,
  input  logic [DATA_W-1:0] ReadData2,
  output logic              dbg_state
);

  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              resp_a_valid_q, resp_a_valid_d;
  logic              resp_b_valid_q, resp_b_valid_d;
  logic [DATA_W-1:0] resp_a_data_q, resp_a_data_d;
  logic [DATA_W-1:0] resp_b_data_q, resp_b_data_d;
  logic              run;
  logic [1:0]        wr_req;
  logic [1:0]        wr_gnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= INIT;
      clr_cnt_q <= FIRST_REG;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      INIT: begin
        clr_cnt_d = clr_cnt_q + FIRST_REG;
        if (clr_cnt_q == LAST_REG) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  assign run       = (state_q == RUN);
  assign dbg_state = state_q;
  assign wr_req    = {ReqB_valid & ReqB_write & run, ReqA_valid & ReqA_write & run};

  // A non-zero grant is always a completed write handshake.
  rr_arb2 u_wr_arb (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .req     (wr_req),
    .advance (|wr_gnt),
    .grant   (wr_gnt)
  );

  always_comb begin
    InitDone      = run;
    ReqA_ready    = run && (!ReqA_write || !wr_gnt[1]);
    ReqB_ready    = run && (!ReqB_write || !wr_gnt[0]);
    ReadRegister1 = run ? ReqA_addr : '0;
    ReadRegister2 = run ? ReqB_addr : '0;
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    if (!run) begin
      // The clear writes stop the moment reset is asserted, not at the next edge.
      RegWrite      = Reset_n;
      WriteRegister = Reset_n ? clr_cnt_q : '0;
    end else if (wr_gnt[0]) begin
      RegWrite      = 1'b1;
      WriteRegister = ReqA_addr;
      WriteData     = ReqA_data;
    end else if (wr_gnt[1]) begin
      RegWrite      = 1'b1;
      WriteRegister = ReqB_addr;
      WriteData     = ReqB_data;
    end
  end

  always_comb begin
    resp_a_valid_d = run && ReqA_valid && !ReqA_write;
    resp_b_valid_d = run && ReqB_valid && !ReqB_write;
    resp_a_data_d  = resp_a_valid_d ? ReadData1 : resp_a_data_q;
    resp_b_data_d  = resp_b_valid_d ? ReadData2 : resp_b_data_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      resp_a_valid_q <= 1'b0;
      resp_b_valid_q <= 1'b0;
      resp_a_data_q  <= '0;
      resp_b_data_q  <= '0;
    end else begin
      resp_a_valid_q <= resp_a_valid_d;
      resp_b_valid_q <= resp_b_valid_d;
      resp_a_data_q  <= resp_a_data_d;
      resp_b_data_q  <= resp_b_data_d;
    end
  end

  assign RespA_valid = resp_a_valid_q;
  assign RespB_valid = resp_b_valid_q;
  assign RespA_data  = resp_a_data_q;
  assign RespB_data  = resp_b_data_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter with a small behavioural register file
// attached to its write and read ports.
module tb_regfile_port_arbiter;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          ReqA_valid, ReqA_write, ReqB_valid, ReqB_write;
  logic [AW-1:0] ReqA_addr, ReqB_addr;
  logic [DW-1:0] ReqA_data, ReqB_data;
  logic          ReqA_ready, ReqB_ready, RespA_valid, RespB_valid;
  logic [DW-1:0] RespA_data, RespB_data;
  logic          InitDone, RegWrite, dbg_state;
  logic [DW-1:0] WriteData, ReadData1, ReadData2;
  logic [AW-1:0] WriteRegister, ReadRegister1, ReadRegister2;

  always #5 Clk = ~Clk;

  regfile_port_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReqA_valid(ReqA_valid), .ReqA_write(ReqA_write), .ReqA_addr(ReqA_addr),
    .ReqA_data(ReqA_data), .ReqA_ready(ReqA_ready),
    .RespA_valid(RespA_valid), .RespA_data(RespA_data),
    .ReqB_valid(ReqB_valid), .ReqB_write(ReqB_write), .ReqB_addr(ReqB_addr),
    .ReqB_data(ReqB_data), .ReqB_ready(ReqB_ready),
    .RespB_valid(RespB_valid), .RespB_data(RespB_data),
    .InitDone(InitDone), .WriteData(WriteData), .WriteRegister(WriteRegister),
    .RegWrite(RegWrite), .ReadRegister1(ReadRegister1), .ReadData1(ReadData1),
    .ReadRegister2(ReadRegister2), .ReadData2(ReadData2), .dbg_state(dbg_state)
  );

  // Register file: poisoned while reset is held so a missing clear shows up.
  logic [DW-1:0] rf [NR];
  always @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 1; i < NR; i++) rf[i] <= 32'hDEAD_0000 | i;
    end else if (RegWrite && WriteRegister != 0) begin
      rf[WriteRegister] <= WriteData;
    end
  end
  assign ReadData1 = (ReadRegister1 == 0) ? '0 : rf[ReadRegister1];
  assign ReadData2 = (ReadRegister2 == 0) ? '0 : rf[ReadRegister2];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic av, aw; logic [AW-1:0] aa; logic [DW-1:0] ad;
    logic bv, bw; logic [AW-1:0] ba; logic [DW-1:0] bd;
    logic e_ra, e_rb, e_rw; logic [AW-1:0] e_wr; logic [DW-1:0] e_wd;
    logic e_rva; logic [DW-1:0] e_rda;
    logic e_rvb; logic [DW-1:0] e_rdb;
  } vec_t;

  function automatic vec_t mkv(
    input logic av, aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
    input logic bv, bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
    input logic e_ra, e_rb, e_rw, input logic [AW-1:0] e_wr, input logic [DW-1:0] e_wd,
    input logic e_rva, input logic [DW-1:0] e_rda,
    input logic e_rvb, input logic [DW-1:0] e_rdb);
    vec_t v;
    v.av = av; v.aw = aw; v.aa = aa; v.ad = ad;
    v.bv = bv; v.bw = bw; v.ba = ba; v.bd = bd;
    v.e_ra = e_ra; v.e_rb = e_rb; v.e_rw = e_rw; v.e_wr = e_wr; v.e_wd = e_wd;
    v.e_rva = e_rva; v.e_rda = e_rda; v.e_rvb = e_rvb; v.e_rdb = e_rdb;
    return v;
  endfunction

  // Entered just after a negedge; leaves just after the following negedge.
  task automatic apply(input vec_t v);
    ReqA_valid = v.av; ReqA_write = v.aw; ReqA_addr = v.aa; ReqA_data = v.ad;
    ReqB_valid = v.bv; ReqB_write = v.bw; ReqB_addr = v.ba; ReqB_data = v.bd;
    #1;
    if (v.av) chk("ready_a", ReqA_ready, v.e_ra);
    if (v.bv) chk("ready_b", ReqB_ready, v.e_rb);
    chk("reg_write", RegWrite, v.e_rw);
    chk("write_reg", WriteRegister, v.e_wr);
    chk("write_data", WriteData, v.e_wd);
    chk("read_reg1", ReadRegister1, v.aa);
    chk("read_reg2", ReadRegister2, v.ba);
    @(posedge Clk);
    @(negedge Clk);
    chk("resp_a_valid", RespA_valid, v.e_rva);
    chk("resp_b_valid", RespB_valid, v.e_rvb);
    if (v.e_rva) chk("resp_a_data", RespA_data, v.e_rda);
    if (v.e_rvb) chk("resp_b_data", RespB_data, v.e_rdb);
  endtask

  task automatic idle_inputs();
    ReqA_valid = 0; ReqA_write = 0; ReqA_addr = 0; ReqA_data = 0;
    ReqB_valid = 0; ReqB_write = 0; ReqB_addr = 0; ReqB_data = 0;
  endtask

  task automatic reset_check();
    chk("rst_ready_a", ReqA_ready, 0);
    chk("rst_ready_b", ReqB_ready, 0);
    chk("rst_resp_a_valid", RespA_valid, 0);
    chk("rst_resp_b_valid", RespB_valid, 0);
    chk("rst_resp_a_data", RespA_data, 0);
    chk("rst_resp_b_data", RespB_data, 0);
    chk("rst_init_done", InitDone, 0);
    chk("rst_read_reg1", ReadRegister1, 0);
    chk("rst_read_reg2", ReadRegister2, 0);
    chk("rst_reg_write", RegWrite, 0);
    chk("rst_write_reg", WriteRegister, 0);
    chk("rst_write_data", WriteData, 0);
  endtask

  // Entered at a negedge right after reset release; requests are held
  // throughout to show they are refused while clearing.
  task automatic run_init(input int abort_at);
    ReqA_valid = 1; ReqA_write = 0; ReqA_addr = 5'd1; ReqA_data = 0;
    ReqB_valid = 1; ReqB_write = 1; ReqB_addr = 5'd3; ReqB_data = 32'h55;
    for (int i = 1; i < NR; i++) begin
      #1;
      chk("init_reg_write", RegWrite, 1);
      chk("init_write_reg", WriteRegister, i);
      chk("init_write_data", WriteData, 0);
      chk("init_ready_a", ReqA_ready, 0);
      chk("init_ready_b", ReqB_ready, 0);
      chk("init_done_early", InitDone, 0);
      if (i == abort_at) begin
        #1 Reset_n = 0;
        #1 reset_check();
        @(negedge Clk);
        Reset_n = 1;
        return;
      end
      @(posedge Clk);
      @(negedge Clk);
    end
    idle_inputs();
    #1 chk("init_done", InitDone, 1);
    @(negedge Clk);
  endtask

  vec_t tbl[$];
  logic [DW-1:0] ref_rf [NR];
  logic last_b;

  initial begin
    idle_inputs();
    Reset_n = 0;
    @(negedge Clk);
    @(negedge Clk);
    reset_check();
    ReqA_addr = 5'd9;
    ReqB_addr = 5'd17;
    #1 chk("rst_read_reg1_gated", ReadRegister1, 0);
    idle_inputs();
    @(negedge Clk);
    Reset_n = 1;
    run_init(10);
    run_init(0);

    // After the clear every register reads zero on both ports.
    for (int r = 0; r < NR; r++) begin
      apply(mkv(1, 0, AW'(r), 0, 1, 0, AW'(NR - 1 - r), 0,
                1, 1, 0, 0, 0, 1, 0, 1, 0));
    end

    //              av aw aa  ad  bv bw ba  bd   ra rb rw wr  wd   rva rda rvb rdb
    tbl.push_back(mkv(1, 1, 5,  7,  1, 1, 6,  9,   1, 0, 1, 5,  7,   0, 0,  0, 0));
    tbl.push_back(mkv(1, 1, 5,  7,  1, 1, 6,  9,   0, 1, 1, 6,  9,   0, 0,  0, 0));
    tbl.push_back(mkv(1, 1, 5,  7,  0, 0, 0,  0,   1, 0, 1, 5,  7,   0, 0,  0, 0));
    tbl.push_back(mkv(1, 0, 5,  0,  1, 0, 6,  0,   1, 1, 0, 0,  0,   1, 7,  1, 9));
    tbl.push_back(mkv(1, 1, 2,  42, 0, 0, 0,  0,   1, 0, 1, 2,  42,  0, 0,  0, 0));
    tbl.push_back(mkv(1, 0, 2,  0,  1, 0, 2,  0,   1, 1, 0, 0,  0,   1, 42, 1, 42));
    tbl.push_back(mkv(1, 1, 15, 15, 1, 0, 15, 0,   1, 1, 1, 15, 15,  0, 0,  1, 0));
    tbl.push_back(mkv(1, 0, 15, 0,  1, 0, 20, 0,   1, 1, 0, 0,  0,   1, 15, 1, 0));
    tbl.push_back(mkv(1, 1, 0,  15, 0, 0, 0,  0,   1, 0, 1, 0,  15,  0, 0,  0, 0));
    tbl.push_back(mkv(1, 0, 0,  0,  1, 0, 0,  0,   1, 1, 0, 0,  0,   1, 0,  1, 0));
    tbl.push_back(mkv(0, 0, 0,  0,  1, 1, 3,  3,   0, 1, 1, 3,  3,   0, 0,  0, 0));
    tbl.push_back(mkv(1, 1, 4,  4,  1, 1, 7,  8,   1, 0, 1, 4,  4,   0, 0,  0, 0));
    tbl.push_back(mkv(1, 0, 3,  0,  1, 1, 7,  8,   1, 1, 1, 7,  8,   1, 3,  0, 0));
    tbl.push_back(mkv(1, 0, 7,  0,  1, 0, 4,  0,   1, 1, 0, 0,  0,   1, 8,  1, 4));
    tbl.push_back(mkv(0, 0, 0,  0,  0, 0, 0,  0,   0, 0, 0, 0,  0,   0, 0,  0, 0));
    foreach (tbl[i]) apply(tbl[i]);

    // Reset while a read response is pending must drop it at once.
    apply(mkv(1, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 7, 0, 0));
    #1 Reset_n = 0;
    #1 chk("run_rst_resp_a_valid", RespA_valid, 0);
    chk("run_rst_resp_a_data", RespA_data, 0);
    chk("run_rst_init_done", InitDone, 0);
    idle_inputs();
    @(negedge Clk);
    Reset_n = 1;
    run_init(0);

    // Random traffic against a reference: array of register contents plus
    // "who won the last write" (reset: B, so A goes first on a tie).
    for (int i = 0; i < NR; i++) ref_rf[i] = '0;
    last_b = 1'b1;
    begin
      vec_t v;
      logic a_hold, b_hold, ga, gb, wa, wb;
      a_hold = 0; b_hold = 0;
      v = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 600; c++) begin
        if (!a_hold) begin
          v.av = ($urandom_range(0, 3) != 0); v.aw = 1'($urandom_range(0, 1));
          v.aa = AW'($urandom_range(0, NR - 1)); v.ad = $urandom;
        end
        if (!b_hold) begin
          v.bv = ($urandom_range(0, 3) != 0); v.bw = 1'($urandom_range(0, 1));
          v.ba = AW'($urandom_range(0, NR - 1)); v.bd = $urandom;
        end
        wa = v.av && v.aw;
        wb = v.bv && v.bw;
        ga = wa && (!wb || last_b);
        gb = wb && (!wa || !last_b);
        v.e_ra = !v.aw || ga;
        v.e_rb = !v.bw || gb;
        v.e_rw = ga || gb;
        v.e_wr = ga ? v.aa : (gb ? v.ba : '0);
        v.e_wd = ga ? v.ad : (gb ? v.bd : '0);
        v.e_rva = v.av && !v.aw;
        v.e_rvb = v.bv && !v.bw;
        v.e_rda = ref_rf[v.aa];
        v.e_rdb = ref_rf[v.ba];
        apply(v);
        if (ga) begin
          if (v.aa != 0) ref_rf[v.aa] = v.ad;
          last_b = 1'b0;
        end
        if (gb) begin
          if (v.ba != 0) ref_rf[v.ba] = v.bd;
          last_b = 1'b1;
        end
        a_hold = v.av && !v.e_ra;
        b_hold = v.bv && !v.e_rb;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
